// File: rtl/fifoout_rd_sched_if.sv
// AXI read-address / read-data bundle between the DDR controller
// and the video-out FIFO read-burst scheduler.
interface fifoout_rd_sched_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0] axi_araddr;
  logic [7:0]        axi_arlen;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic              axi_rvalid;
  logic              axi_rlast;
  logic              axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rvalid, axi_rlast
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rvalid, axi_rlast
  );
endinterface

// File: rtl/fifoout_rd_sched.sv
// DDR read-burst scheduler keeping the video-out FIFO topped up.
// FIFOOUT_PINGPONG_EN adds rd_buf_sel to pick one of two frame buffers.
module fifoout_rd_sched #(
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 256,
  parameter int LEVEL_W         = 9,
  parameter int BURST_LEN       = 16,
  parameter int FILL_LIMIT      = 224,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FRAME_BEATS     = 115200,
  parameter int BASE_ADDR       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
`ifdef FIFOOUT_PINGPONG_EN
  input  logic               rd_buf_sel,
`endif
  input  logic [LEVEL_W-1:0] wr_water_level,
  output logic               fifo_wr_en,
  output logic [DATA_W-1:0]  fifo_wr_data,
  output logic               busy,
  output logic               frame_err,
  fifoout_rd_sched_if.master axi
);

  localparam int LEN_W = $clog2(BURST_LEN + 1);
  localparam int RW    = $clog2(FRAME_BEATS + 1);
  localparam int PW    = LEVEL_W + 1;
  localparam int CW    = LEVEL_W + 2;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int BSH   = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FBYTE = ADDR_W'(FRAME_BEATS * (DATA_W / 8));

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [RW-1:0]     remain_q, remain_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [PW-1:0]     pend_q;
  logic [OW-1:0]     outs_q;
  logic              rready_q;
  logic              beat_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              ar_hs;
  logic              rd_beat;
  logic [LEN_W-1:0]  cur_len;
  logic              space_ok;
  logic              room_ok;
  logic [ADDR_W-1:0] base_new;

  assign ar_hs   = arvalid_q & axi.axi_arready;
  assign rd_beat = axi.axi_rvalid & rready_q;

  assign cur_len = (32'(remain_q) < 32'(BURST_LEN)) ?
                   LEN_W'(remain_q) : LEN_W'(BURST_LEN);

  assign space_ok = (CW'(wr_water_level) + CW'(pend_q) + CW'(cur_len))
                    <= CW'(FILL_LIMIT);
  assign room_ok  = 32'(outs_q) < 32'(MAX_OUTSTANDING);

`ifdef FIFOOUT_PINGPONG_EN
  assign base_new = rd_buf_sel ? BASE + FBYTE : BASE;
`else
  assign base_new = BASE;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    remain_d  = remain_q;
    len_d     = len_q;
    abort_d   = abort_q;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          base_d   = base_new;
          addr_d   = base_new;
          remain_d = RW'(FRAME_BEATS);
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_start) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          base_d  = base_new;
          state_d = S_DRAIN;
        end else if (space_ok && room_ok) begin
          len_d     = cur_len;
          araddr_d  = addr_q;
          arlen_d   = 8'(cur_len - LEN_W'(1));
          arvalid_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // an abort here still lets the pending AR finish
        if (frame_start && !abort_q) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          base_d  = base_new;
        end
        if (ar_hs) begin
          arvalid_d = 1'b0;
          addr_d    = addr_q + (ADDR_W'(len_q) << BSH);
          remain_d  = remain_q - RW'(len_q);
          state_d   = (abort_d || remain_d == '0) ? S_DRAIN : S_CHECK;
        end
      end
      S_DRAIN: begin
        if (frame_start && !abort_q) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          base_d  = base_new;
        end
        if (outs_q == '0 && pend_q == '0) begin
          if (abort_d) begin
            abort_d  = 1'b0;
            addr_d   = base_d;
            remain_d = RW'(FRAME_BEATS);
            state_d  = S_CHECK;
          end else begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      pend_q    <= '0;
      outs_q    <= '0;
      rready_q  <= 1'b0;
      beat_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      // pending counts a beat until its FIFO write slot, kept or dropped
      pend_q    <= pend_q + (ar_hs ? PW'(len_q) : PW'(0)) - PW'(beat_q);
      outs_q    <= outs_q + OW'(ar_hs) - OW'(rd_beat & axi.axi_rlast);
      rready_q  <= 1'b1;
      beat_q    <= rd_beat;
      wr_en_q   <= rd_beat & ~abort_d;
      if (rd_beat) begin
        wr_data_q <= axi.axi_rdata;
      end
    end
  end

  assign axi.axi_araddr  = araddr_q;
  assign axi.axi_arlen   = arlen_q;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_rready  = rready_q;
  assign fifo_wr_en      = wr_en_q;
  assign fifo_wr_data    = wr_data_q;
  assign busy            = (state_q != S_IDLE);
  assign frame_err       = err_q;

endmodule

// File: tb/tb_fifoout_rd_sched.sv
// Randomized bench for fifoout_rd_sched with an AXI slave model
// and a burst-list reference built from frame arithmetic.
module tb_fifoout_rd_sched;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int LW = 9;
  localparam int BL = 16;
  localparam int FL = 224;
  localparam int MO = 2;
  localparam int FB = 40;
  localparam int BY = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [LW-1:0] wr_water_level = '0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic          frame_err;
`ifdef FIFOOUT_PINGPONG_EN
  logic          rd_buf_sel = 1'b0;
`endif

  fifoout_rd_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fifoout_rd_sched #(
    .ADDR_W(AW), .DATA_W(DW), .LEVEL_W(LW), .BURST_LEN(BL),
    .FILL_LIMIT(FL), .MAX_OUTSTANDING(MO), .FRAME_BEATS(FB),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
`ifdef FIFOOUT_PINGPONG_EN
    .rd_buf_sel(rd_buf_sel),
`endif
    .wr_water_level(wr_water_level),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .busy(busy),
    .frame_err(frame_err),
    .axi(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    bit            drop;
  } burst_t;

  burst_t exp_ar[$];
  burst_t rq[$];

  int n_vec = 0;
  int n_err = 0;

  // 0: ready, 1: random, 2: held off, 3: ready while credit lasts
  int ar_mode = 0;
  int ar_credit = 0;
  int r_mode = 0;
  bit lvl_rand = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  int outs_tb = 0;
  int rq_beat = 0;

  bit            beat_prev = 0;
  bit            drop_prev = 0;
  logic [DW-1:0] data_prev = '0;
  bit            prev_arv = 0;
  bit            prev_hs = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [AW-1:0] base, input bit drop);
    for (int b = 0; b < FB; b += BL) begin
      exp_ar.push_back(burst_t'{
        addr: base + AW'(b * BY),
        len:  (FB - b < BL) ? FB - b : BL,
        drop: drop});
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", DW'(busy), DW'(0));
  endtask

  task automatic end_frame(input string tag);
    chk({tag, "_wr_cnt"}, DW'(wr_cnt), DW'(FB));
    chk({tag, "_ar_left"}, DW'(exp_ar.size()), DW'(0));
    chk({tag, "_r_left"}, DW'(rq.size()), DW'(0));
    chk({tag, "_err"}, DW'(frame_err), DW'(0));
  endtask

  // AXI slave, level driver and output monitor, all at negedge
  initial begin
    logic [DW-1:0] d;
    bit            last;
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rlast   = 1'b0;
    bus.axi_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;

      if (beat_prev || fifo_wr_en)
        chk("wr_en", DW'(fifo_wr_en), DW'(beat_prev && !drop_prev));
      if (fifo_wr_en && beat_prev && !drop_prev)
        chk("wr_data", fifo_wr_data, data_prev);
      if (fifo_wr_en) wr_cnt++;

      if (prev_arv && !prev_hs)
        chk("ar_hold",
            DW'({bus.axi_arvalid, bus.axi_araddr, bus.axi_arlen}),
            DW'({1'b1, prev_addr, prev_len}));

      beat_prev = 0;
      last = 0;
      if (rq.size() > 0 && r_mode != 2 &&
          (r_mode == 0 || $urandom_range(0, 2) != 0)) begin
        chk("rready", DW'(bus.axi_rready), DW'(1));
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        rq_beat++;
        last = (rq_beat == rq[0].len);
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = d;
        bus.axi_rlast  = last;
        beat_prev = 1;
        drop_prev = rq[0].drop;
        data_prev = d;
        if (last) begin
          void'(rq.pop_front());
          rq_beat = 0;
          outs_tb--;
        end
      end else begin
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
      end

      if (lvl_rand) wr_water_level = LW'($urandom_range(0, 180));

      case (ar_mode)
        0:       bus.axi_arready = 1'b1;
        1:       bus.axi_arready = 1'($urandom_range(0, 1));
        3:       bus.axi_arready = (ar_credit > 0);
        default: bus.axi_arready = 1'b0;
      endcase

      prev_arv  = bus.axi_arvalid;
      prev_addr = bus.axi_araddr;
      prev_len  = bus.axi_arlen;
      prev_hs   = bus.axi_arvalid && bus.axi_arready;
      if (prev_hs) begin
        burst_t e;
        hs_cnt++;
        if (ar_mode == 3) ar_credit--;
        chk("outstanding", DW'((outs_tb + int'(last)) < MO), DW'(1));
        chk("ar_queued", DW'(exp_ar.size() > 0), DW'(1));
        if (exp_ar.size() > 0) begin
          e = exp_ar.pop_front();
          chk("araddr", DW'(bus.axi_araddr), DW'(e.addr));
          chk("arlen", DW'(bus.axi_arlen), DW'(e.len - 1));
        end else begin
          e = burst_t'{addr: bus.axi_araddr, len: 0, drop: 1'b1};
        end
        e.len = int'(bus.axi_arlen) + 1;
        rq.push_back(e);
        outs_tb++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0;
    tick(1);
    chk("rst_arvalid", DW'(bus.axi_arvalid), DW'(0));
    chk("rst_araddr", DW'(bus.axi_araddr), DW'(0));
    chk("rst_arlen", DW'(bus.axi_arlen), DW'(0));
    chk("rst_rready", DW'(bus.axi_rready), DW'(0));
    chk("rst_wr_en", DW'(fifo_wr_en), DW'(0));
    chk("rst_wr_data", fifo_wr_data, DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_err", DW'(frame_err), DW'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rready_up", DW'(bus.axi_rready), DW'(1));

    // basic frame: 0x000/15, 0x200/15, 0x400/7
    ar_mode = 0; r_mode = 0; wr_cnt = 0;
    push_frame('0, 0);
    pulse_fs();
    chk("lat_cycle1", DW'(bus.axi_arvalid), DW'(0));
    tick(1);
    chk("lat_cycle2", DW'(bus.axi_arvalid), DW'(1));
    chk("busy_up", DW'(busy), DW'(1));
    wait_idle(500);
    end_frame("basic");

    // level gating
    r_mode = 2; wr_water_level = LW'(220); wr_cnt = 0;
    push_frame('0, 0);
    h0 = hs_cnt;
    pulse_fs();
    tick(20);
    chk("lvl220_ar", DW'(hs_cnt - h0), DW'(0));
    wr_water_level = LW'(209);
    tick(10);
    chk("lvl209_ar", DW'(hs_cnt - h0), DW'(0));
    wr_water_level = LW'(208);
    tick(10);
    chk("lvl208_ar", DW'(hs_cnt - h0), DW'(1));
    wr_water_level = '0; r_mode = 0;
    wait_idle(500);
    end_frame("level");

    // arready held low on the second burst
    ar_mode = 3; ar_credit = 1; wr_cnt = 0;
    push_frame('0, 0);
    pulse_fs();
    tick(8);
    chk("stall_arvalid", DW'(bus.axi_arvalid), DW'(1));
    chk("stall_araddr", DW'(bus.axi_araddr), DW'(32'h200));
    tick(5);
    ar_mode = 0;
    wait_idle(500);
    end_frame("stall");

    // outstanding limit with R channel held
    r_mode = 2; wr_cnt = 0;
    push_frame('0, 0);
    h0 = hs_cnt;
    pulse_fs();
    tick(20);
    chk("mo_two", DW'(hs_cnt - h0), DW'(2));
    chk("mo_held", DW'(bus.axi_arvalid), DW'(0));
    r_mode = 0;
    tick(40);
    chk("mo_third", DW'(hs_cnt - h0), DW'(3));
    wait_idle(500);
    end_frame("maxout");

    // abort while the second AR is still waiting for arready
    r_mode = 2; ar_mode = 3; ar_credit = 1;
    exp_ar.push_back(burst_t'{addr: AW'(0),     len: BL, drop: 1'b1});
    exp_ar.push_back(burst_t'{addr: AW'('h200), len: BL, drop: 1'b1});
    pulse_fs();
    tick(8);
    chk("abort_pre_arvalid", DW'(bus.axi_arvalid), DW'(1));
    pulse_fs();
    tick(1);
    chk("abort_err", DW'(frame_err), DW'(1));
    chk("abort_busy", DW'(busy), DW'(1));
    push_frame('0, 0);
    wr_cnt = 0;
    ar_mode = 0; r_mode = 0;
    tick(5);
    pulse_fs();
    wait_idle(1000);
    end_frame("abort");

    // randomized traffic
    for (int f = 0; f < 6; f++) begin
      ar_mode = 1; r_mode = 1; lvl_rand = 1; wr_cnt = 0;
      push_frame('0, 0);
      pulse_fs();
      wait_idle(4000);
      end_frame("rand");
    end
    lvl_rand = 0; wr_water_level = '0;

`ifdef FIFOOUT_PINGPONG_EN
    rd_buf_sel = 1'b1; wr_cnt = 0;
    push_frame(AW'(FB * BY), 0);
    pulse_fs();
    rd_buf_sel = 1'b0;
    tick(1);
    chk("pp_araddr", DW'(bus.axi_araddr), DW'(32'h500));
    wait_idle(1000);
    end_frame("pingpong");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifoout_rd_sched.md
# fifoout_rd_sched

DDR read-burst scheduler that keeps the 256-bit output FIFO (the video-out async FIFO, 256 deep on the write side) topped up from the frame buffer. It sits in the DDR user-clock domain between the AXI read channel of the DDR controller and the FIFO write port. It walks one frame of beats per `frame_start` and issues fixed-length bursts only when FIFO space for the whole burst is guaranteed, so `rready` can be held high permanently.

## Interface
- `ADDR_W`, 28, AXI byte-address width
- `DATA_W`, 256, AXI/FIFO write data width; one beat = DATA_W/8 bytes
- `LEVEL_W`, 9, width of FIFO `wr_water_level`
- `BURST_LEN`, 16, beats per full burst (1..256)
- `FILL_LIMIT`, 224, maximum of level + pending beats after an issue
- `MAX_OUTSTANDING`, 2, maximum AR bursts issued but not completed by `rlast`
- `FRAME_BEATS`, 115200, beats per frame (1280x720x32bpp / 256)
- `BASE_ADDR`, 0, frame buffer byte base
- `clk` in 1: DDR user clock, also FIFO `wr_clk`
- `rst_n` in 1: asynchronous active-low reset
- `frame_start` in 1: one-cycle pulse, already synchronous to `clk`
- `wr_water_level` in LEVEL_W: FIFO write-side level
- `fifo_wr_en` out 1: FIFO write enable
- `fifo_wr_data` out DATA_W: FIFO write data
- `axi_araddr` out ADDR_W: burst byte address
- `axi_arlen` out 8: beats−1
- `axi_arvalid` out 1 / `axi_arready` in 1: AR handshake
- `axi_rdata` in DATA_W, `axi_rvalid` in 1, `axi_rlast` in 1, `axi_rready` out 1: R channel
- `busy` out 1: frame in progress or draining
- `frame_err` out 1: sticky; `frame_start` arrived while busy; cleared by the next clean frame completion

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN.
- IDLE: on `frame_start`, load `addr` = base, `remain` = FRAME_BEATS, and go to CHECK.
- CHECK: `len` = min(remain, BURST_LEN). Go to ISSUE when `wr_water_level + pending + len <= FILL_LIMIT` and `outstanding < MAX_OUTSTANDING`. Otherwise stay in CHECK.
- ISSUE: assert `arvalid` with stable `araddr`/`arlen` (`arlen` = len−1) until `arready`. On the handshake:
  - `pending += len`, `outstanding += 1`, `addr += len*DATA_W/8`, `remain -= len`.
  - Go to CHECK if `remain` ≠ 0, else DRAIN.
- DRAIN: wait for `outstanding` == 0 and `pending` == 0, then go to IDLE and deassert `busy`.
- R channel: `axi_rready` = 1 whenever out of reset. Each `rvalid` beat is registered into `fifo_wr_data`/`fifo_wr_en`. `pending` decrements on each `fifo_wr_en`. `outstanding` decrements on `rvalid & rlast`.
- Simultaneous events: an increment and decrement of `pending`/`outstanding` in the same cycle applies both (net).
- Width rules:
  - `pending` is LEVEL_W+1 bits.
  - `remain` is clog2(FRAME_BEATS+1) bits.
  - The space comparison is done at LEVEL_W+2 bits and cannot overflow.
  - `addr` wraps modulo 2^ADDR_W.
- `frame_start` while busy:
  - Set `frame_err` and stop issuing. An in-progress ISSUE completes its handshake first.
  - Go to DRAIN with an abort flag. Beats received during an aborted drain are discarded: `fifo_wr_en` is held 0, but `pending` still decrements.
  - After the drain, restart at base as if `frame_start` arrived in IDLE.
  - Further `frame_start` pulses during an abort drain are absorbed.
- The last burst of a frame is short when FRAME_BEATS mod BURST_LEN ≠ 0.

## Timing
- Reset values: `axi_arvalid` 0, `axi_araddr` 0, `axi_arlen` 0, `axi_rready` 0, `fifo_wr_en` 0, `fifo_wr_data` 0, `busy` 0, `frame_err` 0, state IDLE.
- `frame_start` → first `arvalid` is 2 cycles later (IDLE→CHECK→ISSUE) when space is available.
- `rvalid` beat → `fifo_wr_en` is 1 cycle later; throughput is one beat per clock.
- CHECK uses `wr_water_level` as sampled that cycle. FIFO level lag is covered by FILL_LIMIT margin (≥ 2 bursts below depth).
- Handshake: `arvalid` never drops before `arready`.
- Reset is honored mid-burst. Subsequent R beats arriving before the controller resets are the integrator's concern.

## Configuration
- `FIFOOUT_PINGPONG_EN` defined:
  - Adds input `rd_buf_sel` (1 bit).
  - On `frame_start`, base = BASE_ADDR + `rd_buf_sel` × FRAME_BEATS × DATA_W/8, latched for the frame.
- Undefined: the port is absent and base is always BASE_ADDR.

## Test plan
- Reset, FRAME_BEATS=40, level 0, `arready` held 1 → bursts at 0x000, 0x200, 0x400 with arlen 15, 15, 7; 40 `fifo_wr_en` pulses; `busy` falls after the last beat.
- Level 220, FILL_LIMIT 224 → no `arvalid` until level ≤ 208, then one burst.
- `arready` low 5 cycles → `araddr`/`arlen` held stable, `pending` unchanged until the handshake.
- `rvalid` delayed, MAX_OUTSTANDING=2 → third AR held until the first `rlast`.
- `frame_start` mid-frame with 1 burst outstanding → `frame_err`=1, no `fifo_wr_en` for drained beats, restart at `araddr`=BASE_ADDR.
- With `FIFOOUT_PINGPONG_EN`, `rd_buf_sel`=1, FRAME_BEATS=40 → first `araddr`=0x500.
